// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, FSM states and LFSR constants
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/axi_delay_lfsr.sv
// rtl/axi_delay_lfsr.sv - 8-bit Fibonacci LFSR supplying response delays
module axi_delay_lfsr
  import axi_lite_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] lfsr
);

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite responder over a word SRAM with programmable latency
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int          MEM_AW       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter bit          RANDOM_DELAY = 1'b1,
  parameter int unsigned FIXED_DELAY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic        bvalid
);

  localparam int          DEPTH = 1 << MEM_AW;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];
  logic [7:0]  lfsr;
  logic [2:0]  delay;
  logic        unused_lfsr_bits;

  axi_delay_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .lfsr   (lfsr)
  );

  assign delay            = RANDOM_DELAY ? lfsr[2:0] : 3'(FIXED_DELAY);
  assign unused_lfsr_bits = ^lfsr[7:3];

  // Read channel
  rd_state_t         r_state, r_next;
  logic [31:0]       ar_addr_q, r_addr, r_off;
  logic [2:0]        r_count;
  logic              r_hit;
  logic [MEM_AW-1:0] r_idx;

  // While idle the decode looks straight at araddr so a zero-delay read can load rdata on the handshake
  assign r_addr  = (r_state == R_IDLE) ? araddr : ar_addr_q;
  assign r_off   = r_addr - BASE_ADDR;
  assign r_hit   = {1'b0, r_off} < SPAN;
  assign r_idx   = r_off[MEM_AW+1:2];
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = (delay == 3'd0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_count <= 3'd1) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      r_count   <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && arvalid) begin
        ar_addr_q <= araddr;
        r_count   <= delay;
      end else if (r_state == R_WAIT) begin
        r_count <= r_count - 3'd1;
      end
      if (r_state != R_RESP && r_next == R_RESP) begin
        rdata <= r_hit ? mem[r_idx] : 32'h0;
        rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Write channel
  wr_state_t         w_state, w_next;
  logic              aw_got, w_got, aw_fire, w_fire, aw_have, w_have, w_commit, w_hit;
  logic [31:0]       aw_addr_q, wdata_q, w_off;
  logic [3:0]        wstrb_q;
  logic [2:0]        w_count;
  logic [MEM_AW-1:0] w_idx;

  assign awready  = (w_state == W_IDLE) && !aw_got;
  assign wready   = (w_state == W_IDLE) && !w_got;
  assign bvalid   = (w_state == W_RESP);
  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign aw_have  = aw_got || aw_fire;
  assign w_have   = w_got || w_fire;
  assign w_off    = aw_addr_q - BASE_ADDR;
  assign w_hit    = {1'b0, w_off} < SPAN;
  assign w_idx    = w_off[MEM_AW+1:2];
  assign w_commit = (w_state == W_WAIT) && (w_next == W_RESP);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_have && w_have) w_next = W_WAIT;
      W_WAIT:  if (w_count <= 3'd1) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_count   <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_fire) aw_addr_q <= awaddr;
      if (w_fire) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_state == W_IDLE) begin
        if (aw_have && w_have) begin
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
          w_count <= delay;
        end else begin
          aw_got <= aw_have;
          w_got  <= w_have;
        end
      end else if (w_state == W_WAIT) begin
        w_count <= w_count - 3'd1;
      end
      if (w_commit) bresp <= w_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Same-edge read capture sees the old word, so a colliding read returns pre-write data
  always_ff @(posedge clock) begin
    if (!reset && w_commit && w_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
